qam_mapper_mm: RTL and testbench

- Multi-mode QAM symbol mapper with symbol-rate pacing. Successor to the fixed 16-QAM mapping stage.
- Accepts 2/4/6-bit words over a valid/ready handshake and Gray-maps them to signed I/Q levels for QPSK, 16-QAM or 64-QAM.
- Holds each symbol for SPS clocks (zero-order hold) and feeds the shaping filter, then the carrier multiplier, in the modulator chain.

---
 rtl/qam_mm_pkg.sv | 60 ++++++
 rtl/qam_gray_map.sv | 45 ++++
 rtl/qam_mapper_mm.sv | 130 +++++++++++++
 tb/tb_qam_mapper_mm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qam_mm_pkg.sv
// -----------------------------------------------------------------------------
// qam_mm_pkg
//   Shared types and helpers for the multi-mode QAM mapper.
//   - qam_mode_e     : constellation select (QPSK / 16-QAM / 64-QAM / reserved)
//   - mapper_state_e : mapper FSM states
//   - lvl_pair_t     : signed I/Q level pair produced by the Gray mapper
//   - gray2lvl_1/2/3 : per-axis Gray code -> odd signed level lookups
// -----------------------------------------------------------------------------
package qam_mm_pkg;

   localparam int DIN_W = 6;   // widest symbol word (64-QAM)
   localparam int LVL_W = 4;   // signed level width, covers -7..+7

   typedef enum logic [1:0] {
      QAM_QPSK = 2'd0,
      QAM_16   = 2'd1,
      QAM_64   = 2'd2,
      QAM_RSVD = 2'd3
   } qam_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mapper_state_e;

   typedef struct packed {
      logic signed [LVL_W-1:0] i;
      logic signed [LVL_W-1:0] q;
   } lvl_pair_t;

   // QPSK axis: a single bit picks the sign
   function automatic logic signed [LVL_W-1:0] gray2lvl_1(input logic g);
      gray2lvl_1 = g ? 4'sd1 : -4'sd1;
   endfunction

   // 16-QAM axis: adjacent levels differ in exactly one bit
   function automatic logic signed [LVL_W-1:0] gray2lvl_2(input logic [1:0] g);
      case (g)
         2'b00:   gray2lvl_2 = -4'sd3;
         2'b01:   gray2lvl_2 = -4'sd1;
         2'b11:   gray2lvl_2 =  4'sd1;
         default: gray2lvl_2 =  4'sd3;   // 2'b10
      endcase
   endfunction

   // 64-QAM axis
   function automatic logic signed [LVL_W-1:0] gray2lvl_3(input logic [2:0] g);
      case (g)
         3'b000:  gray2lvl_3 = -4'sd7;
         3'b001:  gray2lvl_3 = -4'sd5;
         3'b011:  gray2lvl_3 = -4'sd3;
         3'b010:  gray2lvl_3 = -4'sd1;
         3'b110:  gray2lvl_3 =  4'sd1;
         3'b111:  gray2lvl_3 =  4'sd3;
         3'b101:  gray2lvl_3 =  4'sd5;
         default: gray2lvl_3 =  4'sd7;   // 3'b100
      endcase
   endfunction

endpackage

// File: rtl/qam_gray_map.sv
// -----------------------------------------------------------------------------
// qam_gray_map
//   Combinational Gray mapper: splits the input word into I/Q fields according
//   to the constellation and returns signed odd levels per axis.
//   Ports:
//     mode   in  qam_mode_e  constellation select
//     din    in  6           symbol bits, upper bits unused for smaller modes
//     lvl_i  out 4 signed    in-phase level
//     lvl_q  out 4 signed    quadrature level
//   The reserved mode yields zero levels; the top never loads a symbol in it.
// -----------------------------------------------------------------------------
module qam_gray_map
   import qam_mm_pkg::*;
(
   input  qam_mode_e               mode,
   input  logic [DIN_W-1:0]        din,
   output logic signed [LVL_W-1:0] lvl_i,
   output logic signed [LVL_W-1:0] lvl_q
);

   lvl_pair_t lvl;

   always_comb begin
      lvl = '0;
      case (mode)
         QAM_QPSK: begin
            lvl.i = gray2lvl_1(din[1]);
            lvl.q = gray2lvl_1(din[0]);
         end
         QAM_16: begin
            lvl.i = gray2lvl_2(din[3:2]);
            lvl.q = gray2lvl_2(din[1:0]);
         end
         QAM_64: begin
            lvl.i = gray2lvl_3(din[5:3]);
            lvl.q = gray2lvl_3(din[2:0]);
         end
         default: lvl = '0;
      endcase
   end

   assign lvl_i = lvl.i;
   assign lvl_q = lvl.q;

endmodule

// File: rtl/qam_mapper_mm.sv
// -----------------------------------------------------------------------------
// qam_mapper_mm
//   Multi-mode QAM symbol mapper with zero-order hold at SPS clocks/symbol.
//   Ports:
//     axi_clk       in   clock
//     axi_rstn      in   synchronous active-low reset
//     mode          in   2   0=QPSK 1=16-QAM 2=64-QAM 3=reserved
//     din_valid     in   1   input word valid
//     din           in   6   input bits
//     din_ready     out  1   word accepted this cycle if din_valid
//     sym_valid     out  1   sym_i/sym_q carry a live symbol
//     sym_strobe    out  1   pulse on first clock of each symbol
//     sym_i, sym_q  out  OUT_WIDTH signed levels scaled by 2^(OUT_WIDTH-4)
//     mode_err      out  1   reserved mode requested while idle
//     underrun_cnt  out  CNT_WIDTH saturating RUN->IDLE underrun count
// -----------------------------------------------------------------------------
module qam_mapper_mm
   import qam_mm_pkg::*;
#(
   parameter int OUT_WIDTH = 16,
   parameter int SPS       = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        axi_clk,
   input  logic                        axi_rstn,
   input  logic [1:0]                  mode,
   input  logic                        din_valid,
   input  logic [DIN_W-1:0]            din,
   output logic                        din_ready,
   output logic                        sym_valid,
   output logic                        sym_strobe,
   output logic signed [OUT_WIDTH-1:0] sym_i,
   output logic signed [OUT_WIDTH-1:0] sym_q,
   output logic                        mode_err,
   output logic [CNT_WIDTH-1:0]        underrun_cnt
);

   localparam int PH_W  = (SPS > 2) ? $clog2(SPS) : 1;
   localparam int SHIFT = OUT_WIDTH - LVL_W;
   localparam logic [PH_W-1:0]      PH_LAST = PH_W'(SPS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   mapper_state_e   state;
   logic [PH_W-1:0] phase;
   qam_mode_e       mode_q;
   logic            ready_en;   // low through reset and its release cycle edge

   qam_mode_e               map_mode;
   logic signed [LVL_W-1:0] lvl_i, lvl_q;
   logic [OUT_WIDTH-1:0]    scl_i, scl_q;
   logic                    idle, last, accept;

   assign idle   = (state == ST_IDLE);
   assign last   = (state == ST_RUN) && (phase == PH_LAST);

   // Handshake outputs are combinational: IDLE readiness follows the live mode
   // input, and in RUN only the final phase of the hold opens the window so
   // the next symbol lands gap-free.
   assign din_ready = ready_en & (idle ? (mode != 2'(QAM_RSVD)) : last);
   assign mode_err  = ready_en & idle & (mode == 2'(QAM_RSVD));
   assign accept    = din_valid & din_ready;

   // Mode is only sampled on an IDLE accept; back-to-back loads in RUN reuse
   // the latched mode, so mid-stream mode changes have no effect.
   assign map_mode = idle ? qam_mode_e'(mode) : mode_q;

   qam_gray_map u_gray_map (
      .mode  (map_mode),
      .din   (din),
      .lvl_i (lvl_i),
      .lvl_q (lvl_q)
   );

   // level * 2^(OUT_WIDTH-4): sign-extend then shift; +-7 always fits
   assign scl_i = {{(OUT_WIDTH-LVL_W){lvl_i[LVL_W-1]}}, lvl_i} << SHIFT;
   assign scl_q = {{(OUT_WIDTH-LVL_W){lvl_q[LVL_W-1]}}, lvl_q} << SHIFT;

   always_ff @(posedge axi_clk) begin
      if (!axi_rstn) begin
         state        <= ST_IDLE;
         phase        <= '0;
         mode_q       <= QAM_QPSK;
         ready_en     <= 1'b0;
         sym_valid    <= 1'b0;
         sym_strobe   <= 1'b0;
         sym_i        <= '0;
         sym_q        <= '0;
         underrun_cnt <= '0;
      end else begin
         ready_en   <= 1'b1;
         sym_strobe <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_RUN;
                  phase      <= '0;
                  mode_q     <= qam_mode_e'(mode);
                  sym_valid  <= 1'b1;
                  sym_strobe <= 1'b1;
                  sym_i      <= scl_i;
                  sym_q      <= scl_q;
               end
            end
            ST_RUN: begin
               if (last) begin
                  phase <= '0;
                  if (accept) begin
                     sym_valid  <= 1'b1;
                     sym_strobe <= 1'b1;
                     sym_i      <= scl_i;
                     sym_q      <= scl_q;
                  end else begin
                     // underrun: drop the output and count the event
                     state     <= ST_IDLE;
                     sym_valid <= 1'b0;
                     sym_i     <= '0;
                     sym_q     <= '0;
                     if (underrun_cnt != CNT_MAX)
                        underrun_cnt <= underrun_cnt + 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qam_mapper_mm.sv
// -----------------------------------------------------------------------------
// tb_qam_mapper_mm
//   Directed bench for qam_mapper_mm (OUT_WIDTH=16, SPS=8, CNT_WIDTH=4 so the
//   underrun counter saturates within a short run).
// -----------------------------------------------------------------------------
module tb_qam_mapper_mm;

   localparam int OW  = 16;
   localparam int SPS = 8;
   localparam int CW  = 4;
   localparam int CNT_SAT = (1 << CW) - 1;

   logic                 axi_clk = 1'b0;
   logic                 axi_rstn;
   logic [1:0]           mode;
   logic                 din_valid;
   logic [5:0]           din;
   logic                 din_ready;
   logic                 sym_valid;
   logic                 sym_strobe;
   logic signed [OW-1:0] sym_i;
   logic signed [OW-1:0] sym_q;
   logic                 mode_err;
   logic [CW-1:0]        underrun_cnt;

   int checks   = 0;
   int failures = 0;
   int n_under  = 0;

   qam_mapper_mm #(.OUT_WIDTH(OW), .SPS(SPS), .CNT_WIDTH(CW)) dut (
      .axi_clk      (axi_clk),
      .axi_rstn     (axi_rstn),
      .mode         (mode),
      .din_valid    (din_valid),
      .din          (din),
      .din_ready    (din_ready),
      .sym_valid    (sym_valid),
      .sym_strobe   (sym_strobe),
      .sym_i        (sym_i),
      .sym_q        (sym_q),
      .mode_err     (mode_err),
      .underrun_cnt (underrun_cnt)
   );

   always #5 axi_clk = ~axi_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] m;
      logic [5:0] d;
      int         ei;
      int         eq;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge axi_clk);
      #1;
   endtask

   // present a word in IDLE and let the next edge accept it
   task automatic start(input logic [1:0] m, input logic [5:0] d, input string tag);
      mode      = m;
      din       = d;
      din_valid = 1'b1;
      #1;
      chk({tag, " idle ready"}, int'(din_ready), 1);
      step();
   endtask

   // check one full symbol hold; on the last phase present the next input
   task automatic play_sym(input int ei, input int eq, input logic nv,
                           input logic [5:0] nd, input string tag);
      for (int k = 0; k < SPS; k++) begin
         chk({tag, " valid"},  int'(sym_valid), 1);
         chk({tag, " strobe"}, int'(sym_strobe), (k == 0) ? 1 : 0);
         chk({tag, " i"},      int'(sym_i), ei);
         chk({tag, " q"},      int'(sym_q), eq);
         chk({tag, " ready"},  int'(din_ready), (k == SPS-1) ? 1 : 0);
         chk({tag, " moderr"}, int'(mode_err), 0);
         if (k == SPS-1) begin
            din_valid = nv;
            din       = nd;
         end
         step();
      end
   endtask

   // after an underrun: outputs cleared and counter stepped (saturating)
   task automatic check_underrun(input string tag);
      n_under++;
      chk({tag, " uvalid"},  int'(sym_valid), 0);
      chk({tag, " ustrobe"}, int'(sym_strobe), 0);
      chk({tag, " ui"},      int'(sym_i), 0);
      chk({tag, " uq"},      int'(sym_q), 0);
      chk({tag, " ucnt"},    int'(underrun_cnt), (n_under > CNT_SAT) ? CNT_SAT : n_under);
   endtask

   initial begin
      // {mode, din, expected I, expected Q}; U = 4096
      vecs[0]  = '{2'd0, 6'b000010,   4096,  -4096};
      vecs[1]  = '{2'd0, 6'b000001,  -4096,   4096};
      vecs[2]  = '{2'd0, 6'b111100,  -4096,  -4096};
      vecs[3]  = '{2'd1, 6'b001101,   4096,  -4096};
      vecs[4]  = '{2'd1, 6'b000010, -12288,  12288};
      vecs[5]  = '{2'd1, 6'b110111,  -4096,   4096};
      vecs[6]  = '{2'd2, 6'b100000,  28672, -28672};
      vecs[7]  = '{2'd2, 6'b011010, -12288,  -4096};
      vecs[8]  = '{2'd2, 6'b001110, -20480,   4096};
      vecs[9]  = '{2'd2, 6'b111101,  12288,  20480};
      vecs[10] = '{2'd2, 6'b010100,  -4096,  28672};
      vecs[11] = '{2'd2, 6'b110011,   4096, -12288};

      axi_rstn  = 1'b0;
      mode      = 2'd1;
      din_valid = 1'b0;
      din       = '0;
      repeat (3) step();
      chk("rst valid",  int'(sym_valid), 0);
      chk("rst strobe", int'(sym_strobe), 0);
      chk("rst i",      int'(sym_i), 0);
      chk("rst q",      int'(sym_q), 0);
      chk("rst ready",  int'(din_ready), 0);
      chk("rst moderr", int'(mode_err), 0);
      chk("rst cnt",    int'(underrun_cnt), 0);
      axi_rstn = 1'b1;
      step();
      chk("post rst ready",  int'(din_ready), 1);
      chk("post rst moderr", int'(mode_err), 0);
      chk("post rst valid",  int'(sym_valid), 0);

      // single symbols across all modes, each ending in an underrun
      for (int v = 0; v < 12; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         start(vecs[v].m, vecs[v].d, tag);
         play_sym(vecs[v].ei, vecs[v].eq, 1'b0, 6'b0, tag);
         check_underrun(tag);
      end

      // 64-QAM back-to-back, no gap between symbols
      start(2'd2, 6'b100000, "b2b");
      play_sym(28672, -28672, 1'b1, 6'b011010, "b2b0");
      play_sym(-12288, -4096, 1'b0, 6'b0, "b2b1");
      check_underrun("b2b");

      // mode change mid-run is ignored until the next IDLE accept
      start(2'd1, 6'b001101, "tog");
      mode = 2'd2;
      play_sym(4096, -4096, 1'b1, 6'b100010, "tog0");
      play_sym(-12288, 12288, 1'b0, 6'b0, "tog1");
      check_underrun("tog1");
      start(2'd2, 6'b100010, "tog64");
      play_sym(28672, -4096, 1'b0, 6'b0, "tog64");
      check_underrun("tog64");

      // reserved mode blocks acceptance
      mode      = 2'd3;
      din       = 6'b000010;
      din_valid = 1'b1;
      #1;
      chk("m3 ready",  int'(din_ready), 0);
      chk("m3 moderr", int'(mode_err), 1);
      step();
      chk("m3 valid",   int'(sym_valid), 0);
      chk("m3 moderr2", int'(mode_err), 1);
      chk("m3 ready2",  int'(din_ready), 0);
      mode = 2'd1;
      #1;
      chk("m3 fix ready",  int'(din_ready), 1);
      chk("m3 fix moderr", int'(mode_err), 0);
      step();
      play_sym(-12288, 12288, 1'b0, 6'b0, "m3");
      check_underrun("m3");

      // push the counter past its ceiling (2^CW + 2 underruns total)
      while (n_under < (1 << CW) + 2) begin
         start(2'd0, 6'b000010, "sat");
         play_sym(4096, -4096, 1'b0, 6'b0, "sat");
         check_underrun("sat");
      end
      chk("sat cnt", int'(underrun_cnt), CNT_SAT);

      // reset in the middle of a symbol at phase 3
      start(2'd1, 6'b001101, "mrst");
      repeat (3) step();
      chk("mrst pre i", int'(sym_i), 4096);
      axi_rstn = 1'b0;
      step();
      chk("mrst valid",  int'(sym_valid), 0);
      chk("mrst strobe", int'(sym_strobe), 0);
      chk("mrst i",      int'(sym_i), 0);
      chk("mrst q",      int'(sym_q), 0);
      chk("mrst cnt",    int'(underrun_cnt), 0);
      chk("mrst ready",  int'(din_ready), 0);
      axi_rstn  = 1'b1;
      din_valid = 1'b0;
      step();
      chk("mrst post ready", int'(din_ready), 1);
      chk("mrst post valid", int'(sym_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
